// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage.
// Instruction codes, status codes, condition codes and ALU op selection.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_XOR,
    ALU_MUL,
    ALU_BAD
  } alu_op_e;

  // cc is {OF,SF,ZF}
  function automatic logic cond_eval(
    input logic [3:0] ifun,
    input logic [2:0] cc
  );
    logic of, sf, zf, r;
    {of, sf, zf} = cc;
    case (ifun)
      C_YES:   r = 1'b1;
      C_LE:    r = (sf ^ of) | zf;
      C_L:     r = sf ^ of;
      C_E:     r = zf;
      C_NE:    r = ~zf;
      C_GE:    r = ~(sf ^ of);
      C_G:     r = ~(sf ^ of) & ~zf;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_stage_param_iter_mul.sv
// Iterative signed shift-add multiplier, one partial product per cycle.
// Magnitudes are multiplied unsigned; the sign is applied at the end.
module iter_mul #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] prod_lo,
  output logic              ovf
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [2*DATA_W-1:0] mc;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mp;
  logic [CNT_W-1:0]    cnt;
  logic                neg;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     top;

  assign abs_a = a[DATA_W-1] ? -a : a;
  assign abs_b = b[DATA_W-1] ? -b : b;

  // Latch magnitudes on start, then shift-add once per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mc    <= '0;
      acc   <= '0;
      mp    <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mc    <= {{DATA_W{1'b0}}, abs_a};
            mp    <= abs_b;
            neg   <= a[DATA_W-1] ^ b[DATA_W-1];
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (mp[0]) acc <= acc + mc;
          mc  <= mc << 1;
          mp  <= mp >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1))
            state <= S_DONE;
        end
        S_DONE: begin
          if (!hold) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign prod    = neg ? -acc : acc;
  assign prod_lo = prod[DATA_W-1:0];
  assign top     = prod[2*DATA_W-1:DATA_W-1];
  assign ovf     = ~(&top) & (|top);
  assign busy    = (state == S_IDLE && start)
                 || state == S_RUN;
  assign done    = state == S_DONE;

endmodule

// File: rtl/exec_stage_param.sv
// Y86-64 execute stage with CC register and E->M pipeline register.
// Define EXEC_MUL_EN to include the iterative OPq multiply (ifun 4).
module exec_stage_param
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [3:0]        E_destE,
  input  logic [3:0]        E_destM,
  input  logic              setcc,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_destE,
  output logic              e_Cnd,
  output logic              e_busy,
  output logic [2:0]        cc_q,
  output logic [3:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_destE,
  output logic [3:0]        M_destM
);

  localparam int MSB = DATA_W - 1;

  alu_op_e           op;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] dif;
  logic [DATA_W-1:0] alu_r;
  logic              alu_of;
  logic              op_ok;
  logic              bad_op;
  logic              is_op;
  logic              cc_we;
  logic [2:0]        cc_d;
  logic              mul_busy;

`ifdef EXEC_MUL_EN
  logic              mul_done;
  logic              mul_ovf;
  logic [DATA_W-1:0] mul_lo;
  logic              mul_start;

  assign mul_start = is_op && op == ALU_MUL && !M_stall;

  iter_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .hold    (M_stall),
    .a       (E_valA),
    .b       (E_valB),
    .busy    (mul_busy),
    .done    (mul_done),
    .prod_lo (mul_lo),
    .ovf     (mul_ovf)
  );
`else
  assign mul_busy = 1'b0;
`endif

  assign is_op  = E_icode == I_OPQ;
  assign sum    = E_valB + E_valA;
  assign dif    = E_valB - E_valA;
  assign bad_op = is_op && op == ALU_BAD;
  assign e_busy = mul_busy;

  // Map OPq ifun onto an ALU operation
  always_comb begin
    op = ALU_BAD;
    unique case (1'b1)
      (E_ifun == 4'd0): op = ALU_ADD;
      (E_ifun == 4'd1): op = ALU_SUB;
      (E_ifun == 4'd2): op = ALU_AND;
      (E_ifun == 4'd3): op = ALU_XOR;
`ifdef EXEC_MUL_EN
      (E_ifun == 4'd4): op = ALU_MUL;
`endif
      default:          op = ALU_BAD;
    endcase
  end

  // OPq result, overflow flag and completion
  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    op_ok  = 1'b0;
    case (op)
      ALU_ADD: begin
        alu_r  = sum;
        alu_of = (E_valA[MSB] == E_valB[MSB])
              && (sum[MSB] != E_valA[MSB]);
        op_ok  = 1'b1;
      end
      ALU_SUB: begin
        alu_r  = dif;
        alu_of = (E_valA[MSB] != E_valB[MSB])
              && (dif[MSB] != E_valB[MSB]);
        op_ok  = 1'b1;
      end
      ALU_AND: begin
        alu_r = E_valA & E_valB;
        op_ok = 1'b1;
      end
      ALU_XOR: begin
        alu_r = E_valA ^ E_valB;
        op_ok = 1'b1;
      end
`ifdef EXEC_MUL_EN
      ALU_MUL: begin
        alu_r  = mul_done ? mul_lo : '0;
        alu_of = mul_done & mul_ovf;
        op_ok  = mul_done;
      end
`endif
      default: begin
        alu_r  = '0;
        alu_of = 1'b0;
        op_ok  = 1'b0;
      end
    endcase
  end

  // valE selection by instruction class
  always_comb begin
    e_valE = '0;
    case (E_icode)
      I_RRMOVQ:          e_valE = E_valA;
      I_IRMOVQ:          e_valE = E_valC;
      I_RMMOVQ, I_MRMOVQ: e_valE = E_valB + E_valC;
      I_OPQ:             e_valE = alu_r;
      I_CALL, I_PUSHQ:   e_valE = E_valB - DATA_W'(8);
      I_RET, I_POPQ:     e_valE = E_valB + DATA_W'(8);
      default:           e_valE = '0;
    endcase
  end

  assign cc_d  = {alu_of, alu_r[MSB], alu_r == '0};
  assign cc_we = is_op && setcc && op_ok
              && E_stat == STAT_AOK && !M_stall;

  // Condition codes only change when an OPq completes unstalled
  always_ff @(posedge clk) begin
    if (!rst_n)     cc_q <= 3'b001;
    else if (cc_we) cc_q <= cc_d;
  end

  assign e_Cnd = (E_icode == I_RRMOVQ || E_icode == I_JXX)
               ? cond_eval(E_ifun, cc_q) : 1'b0;
  assign e_destE = (E_icode == I_RRMOVQ && !e_Cnd)
                 ? RNONE : E_destE;

  // E->M register: reset > bubble > stall > busy bubble > load
  always_ff @(posedge clk) begin
    if (!rst_n || M_bubble || (!M_stall && e_busy)) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_destE <= RNONE;
      M_destM <= RNONE;
    end else if (!M_stall) begin
      M_stat  <= (bad_op && E_stat == STAT_AOK)
               ? STAT_INS : E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_destE <= e_destE;
      M_destM <= E_destM;
    end
  end

endmodule
